// File: rtl/word_collector.sv
// Serial-to-parallel result collector for the FIOS Montgomery datapath.
// Gathers WORDS LS-first words and offers them on a valid/ready handshake.
module word_collector #(
  parameter int WIDTH = 17,
  parameter int WORDS = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic                     start_i,
  input  logic                     valid_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     ready_i,
  output logic [WORDS*WIDTH-1:0]   data_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic                     error_o
);

  localparam int CNT_W = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [WORDS*WIDTH-1:0]   data_q, data_d;
  logic                     error_q, error_d;
  logic                     restart;

  // In FULL a start only counts when it coincides with the handshake.
  assign restart = start_i && ((state_q != FULL) || ready_i);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    error_d = error_q;
    if (en_i) begin
      if (restart) begin
        state_d = COLLECT;
        error_d = 1'b0;
        count_d = '0;
        if (valid_i) begin
          data_d[WIDTH-1:0] = data_i;
          count_d = CNT_W'(1);
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          COLLECT: begin
            if (valid_i) begin
              for (int k = 0; k < WORDS; k++) begin
                if (count_q == CNT_W'(k)) begin
                  data_d[k*WIDTH +: WIDTH] = data_i;
                end
              end
              count_d = count_q + 1'b1;
              if (count_q + 1'b1 == CNT_W'(WORDS)) begin
                state_d = FULL;
              end
            end
          end
          FULL: begin
            if (valid_i) begin
              error_d = 1'b1;
            end
            if (ready_i) begin
              state_d = IDLE;
              count_d = '0;
            end
          end
          default: begin
            state_d = IDLE;
            count_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == FULL);
  assign busy_o  = (state_q != IDLE);
  assign error_o = error_q;

endmodule

// File: tb/tb_word_collector.sv
// Directed bench for word_collector with a queue-based reference model.
// Model is checked every negedge; literal checks pin key results.
module tb_word_collector;

  localparam int WIDTH = 17;
  localparam int WORDS = 4;
  localparam int WW    = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic             vld = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             rdy = 1'b0;
  logic [WW-1:0]    data_o;
  logic             valid_o;
  logic             busy_o;
  logic             error_o;

  int n_tot = 0;
  int n_pass = 0;

  word_collector #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .en_i    (en),
    .start_i (start),
    .valid_i (vld),
    .data_i  (din),
    .ready_i (rdy),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .error_o (error_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [127:0] act,
                              logic [127:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    else
      n_pass++;
  endfunction

  // Reference model: words gathered so far, held result, flags.
  logic [WIDTH-1:0] words[$];
  logic [WW-1:0]    m_res = '0;
  bit               m_full = 0;
  bit               m_busy = 0;
  bit               m_err = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full = 0;
      m_busy = 0;
      m_err  = 0;
      words.delete();
    end else if (en) begin
      if (start && (!m_full || rdy)) begin
        m_full = 0;
        m_busy = 1;
        m_err  = 0;
        words.delete();
        if (vld) words.push_back(din);
      end else if (m_full) begin
        if (vld) m_err = 1;
        if (rdy) begin
          m_full = 0;
          m_busy = 0;
        end
      end else if (m_busy && vld) begin
        words.push_back(din);
        if (words.size() == WORDS) begin
          for (int k = 0; k < WORDS; k++)
            m_res[k*WIDTH +: WIDTH] = words[k];
          m_full = 1;
          words.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_valid", valid_o, m_full);
    chk("cmp_busy", busy_o, m_busy);
    chk("cmp_error", error_o, m_err);
    if (m_full) chk("cmp_data", data_o, m_res);
  end

  task automatic cyc(input bit s, input bit v,
                     input logic [WIDTH-1:0] d,
                     input bit r, input bit e);
    @(negedge clk);
    start = s;
    vld   = v;
    din   = d;
    rdy   = r;
    en    = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WW-1:0] exp_basic;
    logic [WW-1:0] exp_abort;
    logic [WW-1:0] exp_b2b;
    exp_basic = {17'h0AAAA, 17'h1FFFF, 17'h00002, 17'h00001};
    exp_abort = {17'h00040, 17'h00030, 17'h00020, 17'h00010};
    exp_b2b   = {17'h00008, 17'h00007, 17'h00006, 17'h00005};

    #1 rst = 1'b1;
    #1;
    chk("rst_data", data_o, '0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // valid alone in IDLE is ignored
    cyc(0, 1, 17'h1ABCD, 1, 1);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_err", error_o, 1'b0);

    // basic collect
    cyc(1, 1, 17'h00001, 1, 1);
    cyc(0, 1, 17'h00002, 1, 1);
    cyc(0, 1, 17'h1FFFF, 1, 1);
    chk("basic_notyet", valid_o, 1'b0);
    cyc(0, 1, 17'h0AAAA, 1, 1);
    chk("basic_valid", valid_o, 1'b1);
    chk("basic_data", data_o, exp_basic);
    cyc(0, 0, 17'h0, 1, 1);
    chk("basic_hs_valid", valid_o, 1'b0);
    chk("basic_hs_busy", busy_o, 1'b0);

    // gaps plus a 3-cycle freeze with valid high
    cyc(1, 1, 17'h00001, 1, 1);
    cyc(0, 0, 17'h0, 1, 1);
    cyc(0, 0, 17'h0, 1, 1);
    cyc(0, 1, 17'h00002, 1, 1);
    cyc(0, 0, 17'h0, 1, 1);
    cyc(0, 0, 17'h0, 1, 1);
    repeat (3) cyc(0, 1, 17'h15555, 1, 0);
    chk("frz_valid", valid_o, 1'b0);
    cyc(0, 1, 17'h1FFFF, 1, 1);
    cyc(0, 0, 17'h0, 1, 1);
    cyc(0, 0, 17'h0, 1, 1);
    cyc(0, 1, 17'h0AAAA, 0, 1);
    chk("gap_valid", valid_o, 1'b1);
    chk("gap_data", data_o, exp_basic);
    // frozen while full: no handshake despite ready
    cyc(0, 0, 17'h0, 1, 0);
    chk("gap_frz_hold", valid_o, 1'b1);
    cyc(0, 0, 17'h0, 1, 1);
    chk("gap_hs", valid_o, 1'b0);

    // backpressure and overflow
    cyc(1, 1, 17'h00001, 0, 1);
    cyc(0, 1, 17'h00002, 0, 1);
    cyc(0, 1, 17'h1FFFF, 0, 1);
    cyc(0, 1, 17'h0AAAA, 0, 1);
    cyc(0, 1, 17'h12345, 0, 1);
    chk("ovf_err", error_o, 1'b1);
    cyc(1, 0, 17'h0, 0, 1);
    chk("ovf_start_ign", valid_o, 1'b1);
    repeat (3) cyc(0, 0, 17'h0, 0, 1);
    chk("ovf_hold", data_o, exp_basic);
    cyc(0, 0, 17'h0, 1, 1);
    chk("ovf_hs_valid", valid_o, 1'b0);
    chk("ovf_err_sticky", error_o, 1'b1);
    cyc(0, 0, 17'h0, 1, 1);
    chk("ovf_err_idle", error_o, 1'b1);

    // abort and restart
    cyc(1, 1, 17'h00111, 0, 1);
    chk("abort_err_clr", error_o, 1'b0);
    cyc(0, 1, 17'h00222, 0, 1);
    cyc(1, 0, 17'h0, 0, 1);
    cyc(0, 1, 17'h00010, 0, 1);
    cyc(0, 1, 17'h00020, 0, 1);
    cyc(0, 1, 17'h00030, 0, 1);
    cyc(0, 1, 17'h00040, 0, 1);
    chk("abort_valid", valid_o, 1'b1);
    chk("abort_data", data_o, exp_abort);

    // back-to-back: start+valid in the handshake cycle
    cyc(1, 1, 17'h00005, 1, 1);
    chk("b2b_busy0", busy_o, 1'b1);
    chk("b2b_valid0", valid_o, 1'b0);
    cyc(0, 1, 17'h00006, 1, 1);
    chk("b2b_busy1", busy_o, 1'b1);
    cyc(0, 1, 17'h00007, 1, 1);
    cyc(0, 1, 17'h00008, 0, 1);
    chk("b2b_valid", valid_o, 1'b1);
    chk("b2b_data", data_o, exp_b2b);

    // asynchronous reset while full with an error pending
    cyc(0, 1, 17'h00009, 0, 1);
    chk("pre_rst_err", error_o, 1'b1);
    @(negedge clk);
    vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_data", data_o, '0);
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_error", error_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 17'h0, 1, 1);
    chk("post_rst_busy", busy_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
